// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: bundles the sequencer's operand, processor and result
// handshakes plus status outputs.
//   slave  - the sequencer side (mac_sequencer)
//   master - the environment side (operand source, MAC processor, result sink)
// Parameters: DATA_W (operand/result width), LEN_W (length field width).
interface mac_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] proc_a;
    logic [DATA_W-1:0] proc_b;
    logic              proc_en;
    logic              proc_retro;
    logic              proc_done;
    logic [DATA_W-1:0] proc_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              timeout;

    modport slave (
        input  start, len, op_valid, op_a, op_b, proc_done, proc_out, res_ready,
        output op_ready, proc_a, proc_b, proc_en, proc_retro, res_valid, res_data,
               busy, timeout
    );

    modport master (
        output start, len, op_valid, op_a, op_b, proc_done, proc_out, res_ready,
        input  op_ready, proc_a, proc_b, proc_en, proc_retro, res_valid, res_data,
               busy, timeout
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: steps an external MAC processor through a dot product of
// len operand pairs, then presents the accumulated value on a valid/ready
// result port. A WAIT watchdog of TMO cycles aborts with a zero result and a
// sticky timeout flag.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - mac_sequencer_if.slave: start/len request, op_* operand handshake,
//         proc_* processor drive/return, res_* result handshake, busy, timeout
module mac_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int TMO    = 15
) (
    input  logic           clk,
    input  logic           rst,
    mac_sequencer_if.slave bus
);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_first;
    logic [DATA_W-1:0] r_proc_a;
    logic [DATA_W-1:0] r_proc_b;
    logic              r_proc_en;
    logic              r_proc_retro;
    logic [DATA_W-1:0] r_res_data;
    logic              r_timeout;
    logic [TW-1:0]     r_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_first      <= 1'b0;
            r_proc_a     <= '0;
            r_proc_b     <= '0;
            r_proc_en    <= 1'b0;
            r_proc_retro <= 1'b0;
            r_res_data   <= '0;
            r_timeout    <= 1'b0;
            r_tmo        <= '0;
        end else begin
            r_proc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            r_cnt   <= bus.len;
                            r_first <= 1'b1;
                            r_state <= S_FETCH;
                        end else begin
                            r_res_data <= '0;
                            r_state    <= S_OUT;
                        end
                    end
                end
                S_FETCH: begin
                    // proc_en/proc_retro are loaded here so they are already
                    // registered outputs during the ISSUE cycle.
                    if (bus.op_valid) begin
                        r_proc_a     <= bus.op_a;
                        r_proc_b     <= bus.op_b;
                        r_proc_retro <= ~r_first;
                        r_proc_en    <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_first <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.proc_done) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_res_data <= bus.proc_out;
                            r_state    <= S_OUT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else if (r_tmo == TW'(TMO - 1)) begin
                        r_timeout  <= 1'b1;
                        r_res_data <= '0;
                        r_state    <= S_OUT;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready   = (r_state == S_FETCH);
    assign bus.res_valid  = (r_state == S_OUT);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.proc_a     = r_proc_a;
    assign bus.proc_b     = r_proc_b;
    assign bus.proc_en    = r_proc_en;
    assign bus.proc_retro = r_proc_retro;
    assign bus.res_data   = r_res_data;
    assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

    mac_sequencer #(.DATA_W(DW), .LEN_W(LW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // MAC processor model: accumulates on proc_en, returns done one cycle later.
    logic          hang     = 1'b0;
    logic          inj_done = 1'b0;
    logic          m_done;
    logic [DW-1:0] acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= bus.proc_en && !hang;
            if (bus.proc_en)
                acc <= bus.proc_retro ? acc + bus.proc_a * bus.proc_b
                                      : bus.proc_a * bus.proc_b;
        end
    end

    assign bus.proc_done = m_done | inj_done;
    assign bus.proc_out  = acc;

    // proc_en must never be high on two consecutive cycles.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst && bus.proc_en) begin
            total++;
            if (prev_en) begin
                bad++;
                $display("FAIL proc_en_pulse: got high twice in a row, expected single-cycle pulse");
            end
        end
        prev_en = bus.proc_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic start_job(input int n);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    // Presents one pair, checks the ISSUE cycle and the first WAIT cycle.
    task automatic feed_pair(input logic [31:0] a, input logic [31:0] b,
                             input int vdel, input int idx);
        int k;
        k = 0;
        while (!bus.op_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_latency", k, (idx == 0) ? 0 : 1);
        for (int d = 0; d < vdel; d++) begin
            @(negedge clk);
            chk("fetch_stall", {31'd0, bus.op_ready}, 1);
        end
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        chk("issue_en", {31'd0, bus.proc_en}, 1);
        chk("issue_retro", {31'd0, bus.proc_retro}, (idx != 0) ? 1 : 0);
        chk("issue_a", bus.proc_a, a);
        chk("issue_b", bus.proc_b, b);
        @(negedge clk);
        chk("wait_en", {31'd0, bus.proc_en}, 0);
        chk("wait_a", bus.proc_a, a);
        chk("wait_retro", {31'd0, bus.proc_retro}, (idx != 0) ? 1 : 0);
    endtask

    task automatic finish_result(input logic [31:0] expv, input int rdel, input int expk);
        int k;
        k = 0;
        while (!bus.res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("out_latency", k, expk);
        chk("res_data", bus.res_data, expv);
        chk("out_op_ready", {31'd0, bus.op_ready}, 0);
        for (int d = 0; d < rdel; d++) begin
            @(negedge clk);
            chk("res_hold_valid", {31'd0, bus.res_valid}, 1);
            chk("res_hold_data", bus.res_data, expv);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("idle_busy", {31'd0, bus.busy}, 0);
        chk("idle_valid", {31'd0, bus.res_valid}, 0);
    endtask

    task automatic do_job(input int n, input logic [15:0][31:0] a, input logic [15:0][31:0] b,
                          input logic [31:0] expv, input int vdel, input int rdel);
        start_job(n);
        for (int i = 0; i < n; i++)
            feed_pair(a[i], b[i], vdel, i);
        finish_result(expv, rdel, (n == 0) ? 0 : 1);
    endtask

    typedef struct {
        int             n;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [31:0]    expv;
        int             vdel;
        int             rdel;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int n,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] a2, input logic [31:0] b2,
                           input logic [31:0] a3, input logic [31:0] b3,
                           input logic [31:0] expv, input int vdel, input int rdel);
        vec_t v;
        v.n = n;
        v.a[0] = a0; v.b[0] = b0;
        v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2;
        v.a[3] = a3; v.b[3] = b3;
        v.expv = expv;
        v.vdel = vdel;
        v.rdel = rdel;
        tbl.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0][31:0] ta;
        logic [15:0][31:0] tb;
        logic [31:0]       s;
        int                n;

        add_vec(3, 2, 3, 4, 5, 1, 7, 0, 0, 33, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(2, 3, 4, 5, 6, 0, 0, 0, 0, 42, 5, 4);
        add_vec(4, 32'hFFFF_FFFF, 2, 1, 1, 0, 5, 3, 3, 8, 1, 1);
        add_vec(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add_vec(1, 6, 7, 0, 0, 0, 0, 0, 0, 42, 2, 0);

        bus.start     = 1'b0;
        bus.len       = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_op_ready", {31'd0, bus.op_ready}, 0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 0);
        chk("rst_timeout", {31'd0, bus.timeout}, 0);
        chk("rst_proc_en", {31'd0, bus.proc_en}, 0);
        chk("rst_proc_retro", {31'd0, bus.proc_retro}, 0);
        chk("rst_proc_a", bus.proc_a, 0);
        chk("rst_proc_b", bus.proc_b, 0);
        chk("rst_res_data", bus.res_data, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < tbl.size(); t++) begin
            ta = '0;
            tb = '0;
            ta[3:0] = tbl[t].a;
            tb[3:0] = tbl[t].b;
            do_job(tbl[t].n, ta, tb, tbl[t].expv, tbl[t].vdel, tbl[t].rdel);
        end

        // start and proc_done arriving in FETCH must not disturb the job.
        start_job(2);
        inj_done  = 1'b1;
        bus.start = 1'b1;
        bus.len   = LW'(5);
        @(negedge clk);
        inj_done  = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        chk("inj_fetch_hold", {31'd0, bus.op_ready}, 1);
        chk("inj_busy", {31'd0, bus.busy}, 1);
        feed_pair(3, 3, 0, 0);
        feed_pair(4, 4, 0, 1);
        finish_result(25, 1, 1);

        // Processor never answers: watchdog fires after TMO WAIT cycles.
        hang = 1'b1;
        start_job(1);
        feed_pair(9, 9, 0, 0);
        finish_result(0, 2, TMO);
        chk("timeout_sticky", {31'd0, bus.timeout}, 1);
        hang = 1'b0;

        // Reset in WAIT of pair 2 of 3 aborts; next job starts fresh.
        start_job(3);
        feed_pair(2, 3, 0, 0);
        feed_pair(4, 5, 0, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_res_valid", {31'd0, bus.res_valid}, 0);
        chk("abort_timeout", {31'd0, bus.timeout}, 0);
        chk("abort_proc_retro", {31'd0, bus.proc_retro}, 0);
        chk("abort_proc_a", bus.proc_a, 0);
        chk("abort_res_data", bus.res_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_result", {31'd0, bus.res_valid}, 0);
        ta = '0;
        tb = '0;
        ta[0] = 6;
        tb[0] = 7;
        do_job(1, ta, tb, 42, 0, 0);

        // Randomized jobs against a plain sum-of-products reference.
        for (int j = 0; j < 25; j++) begin
            n = (j == 0) ? 15 : int'($urandom_range(0, 15));
            ta = '0;
            tb = '0;
            s  = '0;
            for (int i = 0; i < n; i++) begin
                ta[i] = $urandom;
                tb[i] = $urandom;
                s = s + ta[i] * tb[i];
            end
            do_job(n, ta, tb, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
